// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit that owns the architectural
// HI/LO registers of the MIPS core.
//
// Operations (mdu_op):
//   000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//   101 MTHI, 110 MTLO, 111 reserved (treated as NONE)
// MULT/MULTU/DIV/DIVU take WIDTH CALC cycles plus one FIXUP cycle.
// Divide by zero skips CALC. MTHI/MTLO complete at the edge where they
// are seen.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   mdu_op   operation select, sampled only while idle
//   rs_data  multiplicand / dividend / MTHI-MTLO source
//   rt_data  multiplier / divisor
//   busy     high while an operation is in flight (CALC or FIXUP)
//   done     one-cycle pulse after HI/LO are written by a mul/div
//   hi, lo   architectural HI/LO registers
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               div_zero;
    logic               neg_main;   // negate product / quotient
    logic               neg_rem;    // negate remainder (dividend was negative)
    logic [WIDTH-1:0]   opa;        // multiplicand magnitude, or raw dividend on divide-by-zero
    logic [WIDTH-1:0]   opb;        // divisor magnitude
    logic [2*WIDTH-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}

    logic               signed_op;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        signed_op = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        // Negating the most negative value wraps to itself, which read as
        // unsigned is exactly the required magnitude.
        a_abs = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        b_abs = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

        // Shift-add step: add multiplicand into the upper half when the
        // current multiplier bit (acc[0]) is set; carry is kept for the shift.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);

        // Restoring step: trial-subtract the divisor from the remainder
        // shifted left by one; a clear top bit means no borrow.
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};

        prod_fix = neg_main ? -acc : acc;
        quot_fix = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            opa      <= a_abs;
                            acc      <= {{WIDTH{1'b0}}, b_abs};
                            neg_main <= signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            neg_rem  <= 1'b0;
                            is_div   <= 1'b0;
                            div_zero <= 1'b0;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            opb      <= b_abs;
                            acc      <= {{WIDTH{1'b0}}, a_abs};
                            neg_main <= signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            neg_rem  <= signed_op && rs_data[WIDTH-1];
                            is_div   <= 1'b1;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            if (rt_data == '0) begin
                                // Raw dividend is kept so HI gets it unmodified.
                                opa      <= rs_data;
                                div_zero <= 1'b1;
                                state    <= FIXUP;
                            end else begin
                                div_zero <= 1'b0;
                                state    <= CALC;
                            end
                        end
                        OP_MTHI: hi <= rs_data;
                        OP_MTLO: lo <= rs_data;
                        default: ;
                    endcase
                end

                CALC: begin
                    if (is_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end

                FIXUP: begin
                    if (div_zero) begin
                        hi <= opa;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed operations with hand-computed
// HI/LO literals, plus a cycle-level reference model checked every cycle.
module tb_mul_div_unit;

    localparam int W = 32;

    localparam logic [2:0] NONE  = 3'b000;
    localparam logic [2:0] MULT  = 3'b001;
    localparam logic [2:0] MULTU = 3'b010;
    localparam logic [2:0] DIV   = 3'b011;
    localparam logic [2:0] DIVU  = 3'b100;
    localparam logic [2:0] MTHI  = 3'b101;
    localparam logic [2:0] MTLO  = 3'b110;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   mdu_op = NONE;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .mdu_op  (mdu_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_done = 1'b0;
    int           m_rem = 0;      // edges left until HI/LO are written
    logic [63:0]  m_pend = '0;
    bit           check_en = 1'b0;

    // Literal expectations posted by the stimulus process
    int           lit_seq = 0;
    int           lit_seen = 0;
    string        lit_name = "";
    logic [W-1:0] lit_hi = '0;
    logic [W-1:0] lit_lo = '0;

    function automatic logic [63:0] model_result(input logic [2:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            MULT:  res = 64'(sa * sb);
            MULTU: res = {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Model: results appear a fixed number of edges after acceptance
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_hi = '0; m_lo = '0; m_done = 1'b0; m_rem = 0;
                check_en = 1'b1;
            end else begin
                m_done = 1'b0;
                if (m_rem != 0) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_hi = m_pend[63:32];
                        m_lo = m_pend[31:0];
                        m_done = 1'b1;
                    end
                end else begin
                    case (mdu_op)
                        MULT, MULTU, DIV, DIVU: begin
                            m_pend = model_result(mdu_op, rs_data, rt_data);
                            m_rem = ((mdu_op == DIV || mdu_op == DIVU) && rt_data == 0) ? 1 : 33;
                        end
                        MTHI: m_hi = rs_data;
                        MTLO: m_lo = rs_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle against the model, plus posted literals
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                cmp("busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
                cmp("done", {31'b0, done}, {31'b0, m_done});
                cmp("hi", hi, m_hi);
                cmp("lo", lo, m_lo);
                if (lit_seq != lit_seen) begin
                    lit_seen = lit_seq;
                    cmp({lit_name, ".hi"}, hi, lit_hi);
                    cmp({lit_name, ".lo"}, lo, lit_lo);
                end
            end
        end
    end

    task automatic expect_lit(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
        lit_name = nm;
        lit_hi = eh;
        lit_lo = el;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    // Presents op for exactly one edge; returns just after that edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        mdu_op = op;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        mdu_op = NONE;
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
        int lat;
        lat = ((op == DIV || op == DIVU) && b == 0) ? 1 : 33;
        issue(op, a, b);
        repeat (lat) @(posedge clk);
        #1;
        expect_lit(nm, eh, el);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_lit("reset", 32'h0, 32'h0);

        // Reset in the middle of a multiply
        issue(MULT, 32'd5, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_lit("rst_mid", 32'h0, 32'h0);
        run(MULTU, 32'd3, 32'd4, "multu_3x4", 32'h0, 32'd12);

        run(MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult_neg",    32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",   32'hFFFF_FFFE, 32'h0000_0001);
        run(MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFC, "mult_negneg", 32'h0,         32'd12);
        run(MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin", 32'h4000_0000, 32'h0);

        run(DIV,  32'hFFFF_FFF9, 32'd2,         "div_neg",    32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(DIV,  32'd7,         32'hFFFF_FFFE, "div_negdiv", 32'd1,         32'hFFFF_FFFD);
        run(DIVU, 32'd100,       32'd7,         "divu",       32'd2,         32'd14);
        run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",    32'h0,         32'h8000_0000);
        run(DIVU, 32'hFFFF_FFFF, 32'd1,         "divu_by1",   32'h0,         32'hFFFF_FFFF);
        run(DIVU, 32'h0000_1234, 32'h0,         "divu_zero",  32'h0000_1234, 32'hFFFF_FFFF);
        run(DIV,  32'hFFFF_FFFB, 32'h0,         "div_zero",   32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTHI then MTLO on consecutive edges
        @(posedge clk);
        #1;
        mdu_op = MTHI;
        rs_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mdu_op = MTLO;
        rs_data = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        mdu_op = NONE;
        expect_lit("mthi_mtlo", 32'hDEAD_BEEF, 32'h0BAD_F00D);

        // Ops presented while busy must be ignored
        issue(MULT, 32'd6, 32'd7);
        mdu_op = MTLO;
        rs_data = 32'h5555_5555;
        @(posedge clk);
        #1;
        mdu_op = DIV;
        rs_data = 32'd9;
        rt_data = 32'd3;
        @(posedge clk);
        #1;
        mdu_op = MTHI;
        rs_data = 32'h1;
        @(posedge clk);
        #1;
        mdu_op = NONE;
        expect_lit("busy_hold", 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (30) @(posedge clk);
        #1;
        expect_lit("mult_after_ignored", 32'h0, 32'd42);

        // Operands changing during busy have no effect
        issue(DIVU, 32'd50, 32'd5);
        for (int i = 0; i < 33; i++) begin
            rs_data = $urandom;
            rt_data = $urandom;
            @(posedge clk);
            #1;
        end
        expect_lit("divu_opchg", 32'h0, 32'd10);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
